// File: rtl/rv_defs.sv
// rv_defs: definitions shared by the uRV decode and execute stages.
//   OPC_*      5-bit major opcodes, i.e. ir[6:2].
//   imm_fmt_e  immediate encoding format that an opcode selects.
//   opc_legal  1 when ir[1:0] is 2'b11 and ir[6:2] is a supported opcode.
package rv_defs;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic logic opc_legal(input logic [31:0] ir);
        logic known;
        case (ir[6:2])
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
            OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM:
                known = 1'b1;
            default:
                known = 1'b0;
        endcase
        return known && (ir[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: combinational immediate extraction for one instruction word.
//   ir_i     in   32  raw instruction word
//   imm_o    out  32  sign-extended (or U-type shifted) immediate, 0 if none
//   fmt_o    out  3   immediate format selected by the opcode
//   legal_o  out  1   instruction encoding is supported
module rv_imm_gen
    import rv_defs::*;
(
    input  logic [31:0] ir_i,
    output logic [31:0] imm_o,
    output imm_fmt_e    fmt_o,
    output logic        legal_o
);

    always_comb begin
        imm_o = '0;
        fmt_o = IMM_NONE;
        case (ir_i[6:2])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
                fmt_o = IMM_I;
                imm_o = {{20{ir_i[31]}}, ir_i[31:20]};
            end
            OPC_STORE: begin
                fmt_o = IMM_S;
                imm_o = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o = IMM_B;
                imm_o = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = IMM_U;
                imm_o = {ir_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o = IMM_J;
                imm_o = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            end
            default: begin
                fmt_o = IMM_NONE;
                imm_o = '0;
            end
        endcase
    end

    assign legal_o = opc_legal(ir_i);

endmodule

// File: rtl/rv_decode.sv
// rv_decode: uRV decode stage between fetch and execute.
//   clk_i, rst_n_i                  clock, synchronous active-low reset
//   f_ir_i, f_pc_i, f_ir_valid_i    instruction from fetch
//   f_stall_o                       stall request to fetch (combinational)
//   x_stall_i, x_kill_i             hold / flush requests from execute
//   rf_rs1_o, rf_rs2_o              RF read addresses (combinational)
//   d_*                             registered decoded bundle for execute
module rv_decode
    import rv_defs::*;
#(
    parameter bit          WITH_INTERLOCK = 1'b1,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] f_ir_i,
    input  logic [31:0] f_pc_i,
    input  logic        f_ir_valid_i,
    output logic        f_stall_o,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    output logic        d_valid_o,
    output logic [31:0] d_pc_o,
    output logic [31:0] d_ir_o,
    output logic [4:0]  d_opcode_o,
    output logic [2:0]  d_fun3_o,
    output logic [4:0]  d_rs1_o,
    output logic [4:0]  d_rs2_o,
    output logic [4:0]  d_rd_o,
    output logic [31:0] d_imm_o,
    output logic        d_is_load_o,
    output logic        d_is_store_o,
    output logic        d_is_branch_o,
    output logic        d_illegal_o
);

    // Replay slot: holds the one instruction fetch handed over while stalled.
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] slot_ir_q, slot_ir_d;
    logic [31:0] slot_pc_q, slot_pc_d;

    logic        d_valid_q, d_valid_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_ir_q, d_ir_d;
    logic [31:0] d_imm_q, d_imm_d;
    logic        d_is_load_q, d_is_load_d;
    logic        d_is_store_q, d_is_store_d;
    logic        d_is_branch_q, d_is_branch_d;
    logic        d_illegal_q, d_illegal_d;

    logic        src_valid;
    logic [31:0] src_ir;
    logic [31:0] src_pc;
    logic [4:0]  src_opc;
    logic [31:0] src_imm;
    imm_fmt_e    src_fmt;
    logic        src_legal;
    logic        uses_rs1, uses_rs2, hazard;

    assign src_valid = slot_valid_q ? 1'b1      : f_ir_valid_i;
    assign src_ir    = slot_valid_q ? slot_ir_q : f_ir_i;
    assign src_pc    = slot_valid_q ? slot_pc_q : f_pc_i;
    assign src_opc   = src_ir[6:2];

    assign rf_rs1_o = src_ir[19:15];
    assign rf_rs2_o = src_ir[24:20];

    rv_imm_gen u_imm_gen (
        .ir_i    (src_ir),
        .imm_o   (src_imm),
        .fmt_o   (src_fmt),
        .legal_o (src_legal)
    );

    assign uses_rs1 = !(src_opc == OPC_LUI || src_opc == OPC_AUIPC || src_opc == OPC_JAL);
    assign uses_rs2 = (src_opc == OPC_STORE || src_opc == OPC_OP || src_opc == OPC_BRANCH);

    assign hazard = WITH_INTERLOCK && src_valid && d_valid_q && d_is_load_q &&
                    (d_ir_q[11:7] != 5'd0) &&
                    ((uses_rs1 && src_ir[19:15] == d_ir_q[11:7]) ||
                     (uses_rs2 && src_ir[24:20] == d_ir_q[11:7]));

    assign f_stall_o = x_stall_i || hazard || slot_valid_q;

    always_comb begin
        d_valid_d     = d_valid_q;
        d_pc_d        = d_pc_q;
        d_ir_d        = d_ir_q;
        d_imm_d       = d_imm_q;
        d_is_load_d   = d_is_load_q;
        d_is_store_d  = d_is_store_q;
        d_is_branch_d = d_is_branch_q;
        d_illegal_d   = d_illegal_q;
        slot_valid_d  = slot_valid_q;
        slot_ir_d     = slot_ir_q;
        slot_pc_d     = slot_pc_q;

        if (x_kill_i) begin
            d_valid_d = 1'b0;
        end else if (x_stall_i) begin
            // hold the bundle
        end else if (hazard) begin
            d_valid_d = 1'b0;
        end else begin
            d_valid_d     = src_valid;
            d_pc_d        = src_pc;
            d_ir_d        = src_ir;
            d_imm_d       = src_imm;
            d_is_load_d   = (src_opc == OPC_LOAD);
            d_is_store_d  = (src_fmt == IMM_S);
            d_is_branch_d = (src_fmt == IMM_B);
            d_illegal_d   = !src_legal;
        end

        // An empty slot catches whatever fetch offers while we stall; the
        // slot drains only on a cycle where the bundle actually advances.
        if (x_kill_i) begin
            slot_valid_d = 1'b0;
        end else if (f_stall_o && !slot_valid_q && f_ir_valid_i) begin
            slot_valid_d = 1'b1;
            slot_ir_d    = f_ir_i;
            slot_pc_d    = f_pc_i;
        end else if (!x_stall_i && !hazard) begin
            slot_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            d_valid_q     <= 1'b0;
            d_pc_q        <= RESET_PC;
            d_ir_q        <= '0;
            d_imm_q       <= '0;
            d_is_load_q   <= 1'b0;
            d_is_store_q  <= 1'b0;
            d_is_branch_q <= 1'b0;
            d_illegal_q   <= 1'b0;
            slot_valid_q  <= 1'b0;
            slot_ir_q     <= '0;
            slot_pc_q     <= '0;
        end else begin
            d_valid_q     <= d_valid_d;
            d_pc_q        <= d_pc_d;
            d_ir_q        <= d_ir_d;
            d_imm_q       <= d_imm_d;
            d_is_load_q   <= d_is_load_d;
            d_is_store_q  <= d_is_store_d;
            d_is_branch_q <= d_is_branch_d;
            d_illegal_q   <= d_illegal_d;
            slot_valid_q  <= slot_valid_d;
            slot_ir_q     <= slot_ir_d;
            slot_pc_q     <= slot_pc_d;
        end
    end

    assign d_valid_o     = d_valid_q;
    assign d_pc_o        = d_pc_q;
    assign d_ir_o        = d_ir_q;
    assign d_opcode_o    = d_ir_q[6:2];
    assign d_fun3_o      = d_ir_q[14:12];
    assign d_rs1_o       = d_ir_q[19:15];
    assign d_rs2_o       = d_ir_q[24:20];
    assign d_rd_o        = d_ir_q[11:7];
    assign d_imm_o       = d_imm_q;
    assign d_is_load_o   = d_is_load_q;
    assign d_is_store_o  = d_is_store_q;
    assign d_is_branch_o = d_is_branch_q;
    assign d_illegal_o   = d_illegal_q;

endmodule
